// File: rtl/seq_divider.sv
// Multi-cycle restoring divider: one quotient bit per cycle, unsigned or two's-complement
// operands, start/done handshake and a one-cycle divide-by-zero shortcut.
module seq_divider #(
  parameter int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 neg_quo_q, neg_quo_d;
  logic                 neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0]     quotient_q, quotient_d;
  logic [WIDTH-1:0]     remainder_q, remainder_d;
  logic                 done_q, done_d;
  logic                 dbz_q, dbz_d;
  logic                 busy_q, busy_d;

  logic [WIDTH-1:0]     shifted_hi;
  logic [WIDTH:0]       diff;

  // Magnitudes stay WIDTH-bit unsigned, so |-2^(W-1)| = 2^(W-1) needs no special case.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic take);
    if (take && v[WIDTH-1]) begin
      magnitude = -v;
    end else begin
      magnitude = v;
    end
  endfunction

  // Next-state, datapath and output computation.
  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    done_d      = 1'b0;
    shifted_hi  = rem_q[2*WIDTH-2:WIDTH-1];
    diff        = {1'b0, shifted_hi} - {1'b0, dvs_q};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == {WIDTH{1'b0}}) begin
            quotient_d  = {WIDTH{1'b1}};
            remainder_d = dividend;
            dbz_d       = 1'b1;
            done_d      = 1'b1;
            state_d     = IDLE;
          end else begin
            neg_quo_d = signed_mode & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = signed_mode & dividend[WIDTH-1];
            dvs_d     = magnitude(divisor, signed_mode);
            rem_d     = {{WIDTH{1'b0}}, magnitude(dividend, signed_mode)};
            cnt_d     = {CNT_W{1'b0}};
            dbz_d     = 1'b0;
            state_d   = CALC;
          end
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        // diff[WIDTH] is the borrow: set when the partial remainder is below the divisor.
        if (!diff[WIDTH]) begin
          rem_d = {diff[WIDTH-1:0], rem_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = {rem_q[2*WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FINISH;
        end else begin
          state_d = CALC;
        end
      end
      FINISH: begin
        if (neg_quo_q) begin
          quotient_d = -rem_q[WIDTH-1:0];
        end else begin
          quotient_d = rem_q[WIDTH-1:0];
        end
        if (neg_rem_q) begin
          remainder_d = -rem_q[2*WIDTH-1:WIDTH];
        end else begin
          remainder_d = rem_q[2*WIDTH-1:WIDTH];
        end
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and result registers; reset aborts any division in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      rem_q       <= {(2*WIDTH){1'b0}};
      dvs_q       <= {WIDTH{1'b0}};
      cnt_q       <= {CNT_W{1'b0}};
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quotient_q  <= {WIDTH{1'b0}};
      remainder_q <= {WIDTH{1'b0}};
      done_q      <= 1'b0;
      dbz_q       <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      done_q      <= done_d;
      dbz_q       <= dbz_d;
      busy_q      <= busy_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed vector tables plus random operands for 32- and 8-bit
// instances, checked against an arithmetic reference; handshake corner cases by hand.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start, signed_mode;
  logic [31:0] dividend, divisor, quotient, remainder;
  logic        busy, done, div_by_zero;
  logic        start8, signed_mode8;
  logic [7:0]  dividend8, divisor8, quotient8, remainder8;
  logic        busy8, done8, div_by_zero8;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        sm;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t tab32[10];
  vec_t tab8[5];

  seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .signed_mode(signed_mode),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder), .div_by_zero(div_by_zero)
  );

  seq_divider #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_mode(signed_mode8),
    .dividend(dividend8), .divisor(divisor8), .busy(busy8), .done(done8),
    .quotient(quotient8), .remainder(remainder8), .div_by_zero(div_by_zero8)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference: signed/unsigned integer division in 64 bits, truncating toward zero.
  function automatic void model32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] q, output logic [31:0] r, output logic dbz);
    longint sa, sb, qq, rr;
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; dbz = 1'b1;
    end else begin
      sa = sm ? longint'($signed(a)) : longint'(a);
      sb = sm ? longint'($signed(b)) : longint'(b);
      qq = sa / sb;
      rr = sa % sb;
      q = qq[31:0]; r = rr[31:0]; dbz = 1'b0;
    end
  endfunction

  function automatic void model8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                                 output logic [7:0] q, output logic [7:0] r, output logic dbz);
    int sa, sb, qq, rr;
    if (b == 8'd0) begin
      q = 8'hFF; r = a; dbz = 1'b1;
    end else begin
      sa = sm ? int'($signed(a)) : int'(a);
      sb = sm ? int'($signed(b)) : int'(b);
      qq = sa / sb;
      rr = sa % sb;
      q = qq[7:0]; r = rr[7:0]; dbz = 1'b0;
    end
  endfunction

  task automatic run32(input logic sm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er, input logic edbz,
                       input string tag);
    int n, bc, elat;
    @(negedge clk);
    start = 1'b1; signed_mode = sm; dividend = a; divisor = b;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    bc = int'(busy);
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      bc += int'(busy);
    end
    elat = (b == 32'd0) ? 0 : 33;
    chk({tag, ".done_seen"}, done, 1'b1);
    chk({tag, ".quotient"}, quotient, eq);
    chk({tag, ".remainder"}, remainder, er);
    chk({tag, ".dbz"}, div_by_zero, edbz);
    chk({tag, ".latency"}, n, elat);
    chk({tag, ".busy_cycles"}, bc, elat);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, done, 1'b0);
  endtask

  task automatic run8(input logic sm, input logic [7:0] a, input logic [7:0] b,
                      input logic [7:0] eq, input logic [7:0] er, input logic edbz,
                      input string tag);
    int n;
    @(negedge clk);
    start8 = 1'b1; signed_mode8 = sm; dividend8 = a; divisor8 = b;
    @(posedge clk); #1;
    start8 = 1'b0;
    n = 0;
    while (!done8 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, ".done_seen"}, done8, 1'b1);
    chk({tag, ".quotient"}, quotient8, eq);
    chk({tag, ".remainder"}, remainder8, er);
    chk({tag, ".dbz"}, div_by_zero8, edbz);
    chk({tag, ".latency"}, n, (b == 8'd0) ? 0 : 9);
  endtask

  initial begin
    logic [31:0] ra, rb, eq, er;
    logic [7:0]  ra8, rb8, eq8, er8;
    logic        rs, edbz, seen;
    int          n;

    tab32[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    tab32[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
    tab32[2] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1,          1'b0};
    tab32[3] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1,          1'b0};
    tab32[4] = '{1'b0, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tab32[5] = '{1'b1, 32'd5,          32'd0,          32'hFFFF_FFFF,  32'd5,          1'b1};
    tab32[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0,          1'b0};
    tab32[7] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF,  32'd0,          32'h8000_0000,  1'b0};
    tab32[8] = '{1'b1, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
    tab32[9] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    tab8[0]  = '{1'b0, 32'd200,        32'd13,         32'd15,         32'd5,          1'b0};
    tab8[1]  = '{1'b1, 32'h80,         32'hFF,         32'h80,         32'd0,          1'b0};
    tab8[2]  = '{1'b0, 32'h80,         32'hFF,         32'd0,          32'h80,         1'b0};
    tab8[3]  = '{1'b1, 32'h9C,         32'd7,          32'hF2,         32'hFE,         1'b0};
    tab8[4]  = '{1'b0, 32'd5,          32'd0,          32'hFF,         32'd5,          1'b1};

    reset = 1'b1;
    start = 1'b0; signed_mode = 1'b0; dividend = 32'd0; divisor = 32'd0;
    start8 = 1'b0; signed_mode8 = 1'b0; dividend8 = 8'd0; divisor8 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst.busy", busy, 1'b0);
    chk("rst.done", done, 1'b0);
    chk("rst.quotient", quotient, 32'd0);
    chk("rst.remainder", remainder, 32'd0);
    chk("rst.dbz", div_by_zero, 1'b0);
    chk("rst.quotient8", quotient8, 8'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 10; i++) begin
      run32(tab32[i].sm, tab32[i].a, tab32[i].b, tab32[i].q, tab32[i].r, tab32[i].dbz,
            $sformatf("tab32[%0d]", i));
    end
    for (int i = 0; i < 5; i++) begin
      run8(tab8[i].sm, tab8[i].a[7:0], tab8[i].b[7:0], tab8[i].q[7:0], tab8[i].r[7:0],
           tab8[i].dbz, $sformatf("tab8[%0d]", i));
    end

    for (int i = 0; i < 40; i++) begin
      rs = 1'($urandom);
      ra = $urandom;
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1, 2:    rb = $urandom_range(1, 20);
        3:       rb = 32'hFFFF_FFFF;
        default: rb = $urandom;
      endcase
      if (i % 10 == 0) ra = 32'h8000_0000;
      model32(rs, ra, rb, eq, er, edbz);
      run32(rs, ra, rb, eq, er, edbz, $sformatf("rnd32[%0d]", i));
    end
    for (int i = 0; i < 20; i++) begin
      rs = 1'($urandom);
      ra8 = 8'($urandom);
      rb8 = (i % 7 == 3) ? 8'd0 : 8'($urandom);
      model8(rs, ra8, rb8, eq8, er8, edbz);
      run8(rs, ra8, rb8, eq8, er8, edbz, $sformatf("rnd8[%0d]", i));
    end

    // Reset in the middle of 100/7 must clear everything at once and suppress done.
    run32(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0, "pre_abort");
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    chk("abort.busy", busy, 1'b0);
    chk("abort.done", done, 1'b0);
    chk("abort.quotient", quotient, 32'd0);
    chk("abort.remainder", remainder, 32'd0);
    chk("abort.dbz", div_by_zero, 1'b0);
    @(negedge clk);
    reset = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) seen = 1'b1;
    end
    chk("abort.no_done", seen, 1'b0);
    run32(1'b0, 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, "after_abort");

    // Start pulsed while busy is ignored; start on the done cycle is accepted.
    @(negedge clk);
    start = 1'b1; signed_mode = 1'b0; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
      if (n == 5) begin
        start = 1'b1; dividend = 32'd50; divisor = 32'd5;
      end else begin
        start = 1'b0;
      end
    end
    chk("busy_start.latency", n, 33);
    chk("busy_start.quotient", quotient, 32'd14);
    chk("busy_start.remainder", remainder, 32'd2);
    start = 1'b1; dividend = 32'd50; divisor = 32'd5;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b.busy", busy, 1'b1);
    n = 0;
    while (!done && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("b2b.latency", n, 33);
    chk("b2b.quotient", quotient, 32'd10);
    chk("b2b.remainder", remainder, 32'd0);
    chk("b2b.dbz", div_by_zero, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
